// File: rtl/short_or_long_press_if.sv
`default_nettype none
// ============================================================================
// Module      : short_or_long_press_if
// Description : Button-side bundle for the short/long press classifier.
//               master : drives the raw button level, observes the pulses
//               slave  : the classifier (samples inc, drives both pulses)
//   inc        1  raw button level, asynchronous to the clock, 1 = pressed
//   inc_short  1  one-cycle pulse, a short press was completed
//   inc_long   1  one-cycle pulse, long press reached or repeat tick
// Revision    : 1.0  initial release
// ============================================================================
interface short_or_long_press_if;
  logic inc;
  logic inc_short;
  logic inc_long;

  modport master (output inc, input inc_short, input inc_long);
  modport slave  (input inc, output inc_short, output inc_long);
endinterface
`default_nettype wire

// File: rtl/short_or_long_press.sv
`default_nettype none
// ============================================================================
// Module      : short_or_long_press
// Description : Classifies presses of the "inc" button, sampled on the slow
//               system tick, as short (released before LONG_THRESH samples)
//               or long (held to LONG_THRESH), with optional auto-repeat of
//               inc_long every REPEAT_PERIOD samples while still held.
// Ports       :
//   clk_1Hz  in  sole clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   bus      slave modport: inc in, inc_short / inc_long out (registered)
// Revision    : 1.0  initial release
// ============================================================================
module short_or_long_press #(
  parameter int LONG_THRESH   = 3,
  parameter int REPEAT_PERIOD = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8
) (
  input  wire logic             clk_1Hz,
  input  wire logic             rst_n,
  short_or_long_press_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LONG      = CNT_W'(LONG_THRESH);
  // hold count at which the next high sample completes a long press
  localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_THRESH - 1);
  localparam bit               C_REP_EN    = (REPEAT_PERIOD != 0);
  // repeat count at which the next high sample fires a repeat pulse;
  // only meaningful when repeat is enabled
  localparam logic [CNT_W-1:0] C_REP_LAST  = C_REP_EN ? CNT_W'(REPEAT_PERIOD - 1) : '0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   inc_s;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic [CNT_W-1:0]       rep_q, rep_d;
  logic                   short_q, short_d;
  logic                   long_q, long_d;

  assign inc_s         = sync_q[SYNC_STAGES-1];
  assign bus.inc_short = short_q;
  assign bus.inc_long  = long_q;

  // State register, synchronizer, counters and output flops
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      hold_q  <= '0;
      rep_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q[0] <= bus.inc;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    case (state_q)
      ST_IDLE: begin
        if (inc_s) begin
          state_d = ST_PRESSED;
          hold_d  = C_ONE;
        end
      end
      ST_PRESSED: begin
        if (!inc_s) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (hold_q == C_LONG_LAST) begin
          state_d = ST_LONG;
          hold_d  = C_LONG;  // saturates here for the rest of the hold
          rep_d   = '0;
        end else begin
          hold_d  = hold_q + C_ONE;
        end
      end
      ST_LONG: begin
        if (!inc_s) begin
          state_d = ST_IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end else if (C_REP_EN) begin
          rep_d = (rep_q == C_REP_LAST) ? '0 : rep_q + C_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
        rep_d   = '0;
      end
    endcase
  end

  // Pulse decode; captured by the output flops so the pulses are registered
  always_comb begin
    short_d = (state_q == ST_PRESSED) && !inc_s;
    long_d  = inc_s &&
              (((state_q == ST_PRESSED) && (hold_q == C_LONG_LAST)) ||
               ((state_q == ST_LONG) && C_REP_EN && (rep_q == C_REP_LAST)));
  end

endmodule
`default_nettype wire

// File: tb/tb_short_or_long_press.sv
`default_nettype none
// ============================================================================
// Module      : tb_short_or_long_press
// Description : Self-checking bench for short_or_long_press. A second
//               instance with REPEAT_PERIOD=0 shares the same stimulus.
//               Expected pulses (cycle + kind) are queued when a press is
//               driven and consumed as the DUT emits pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_short_or_long_press;

  localparam int L = 3;
  localparam int R = 2;
  localparam int S = 2;

  typedef struct {
    int cyc;
    bit lng;
  } ev_t;

  logic clk_1Hz = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_short = 0, n_long = 0;
  int   r0_short = 0, r0_long = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  short_or_long_press_if bus ();
  short_or_long_press_if bus0 ();

  short_or_long_press #(.LONG_THRESH(L), .REPEAT_PERIOD(R), .SYNC_STAGES(S), .CNT_W(8)) dut (
    .clk_1Hz (clk_1Hz),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  short_or_long_press #(.LONG_THRESH(L), .REPEAT_PERIOD(0), .SYNC_STAGES(S), .CNT_W(8)) dut_norep (
    .clk_1Hz (clk_1Hz),
    .rst_n   (rst_n),
    .bus     (bus0)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // cyc equals the number of the most recent rising edge
  always @(posedge clk_1Hz) cyc <= cyc + 1;

  // Scoreboard: consume expected pulses as the main DUT emits them
  always @(negedge clk_1Hz) begin
    if (rst_n) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        n_assert++;
        n_fail++;
        $display("FAIL missing_pulse: expected %s at cycle %0d, got no pulse", mon_e.lng ? "long" : "short", mon_e.cyc);
      end
      if (bus.inc_short || bus.inc_long) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: cycle %0d short=%b long=%b, required no pulse", cyc, bus.inc_short, bus.inc_long);
        end else if (exp_q[0].cyc != cyc) begin
          n_fail++;
          $display("FAIL pulse_timing: pulse at cycle %0d, required next pulse at cycle %0d", cyc, exp_q[0].cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.inc_short, bus.inc_long} !== {~mon_e.lng, mon_e.lng}) begin
            n_fail++;
            $display("FAIL pulse_kind: cycle %0d short=%b long=%b, required long=%b", cyc, bus.inc_short, bus.inc_long, mon_e.lng);
          end
        end
        if (bus.inc_long) n_long++;
        else n_short++;
      end
      if (bus.inc_short && bus.inc_long) begin
        n_assert++;
        n_fail++;
        $display("FAIL exclusive: both pulses high at cycle %0d", cyc);
      end
      if (bus0.inc_short) r0_short++;
      if (bus0.inc_long)  r0_long++;
    end
  end

  task automatic set_inc(input logic v);
    bus.inc  = v;
    bus0.inc = v;
  endtask

  // Drive one press of n sampled cycles and queue the pulses it must produce
  task automatic press(input int n);
    int k;
    @(negedge clk_1Hz);
    k = cyc + 1;  // first rising edge that samples the press
    if (n < L) begin
      exp_q.push_back('{cyc: k + S + n, lng: 1'b0});
    end else begin
      for (int i = L; i <= n; i += R) begin
        exp_q.push_back('{cyc: k + S + i - 1, lng: 1'b1});
        if (R == 0) break;
      end
    end
    set_inc(1'b1);
    repeat (n) @(negedge clk_1Hz);
    set_inc(1'b0);
  endtask

  task automatic settle();
    repeat (S + 4) @(negedge clk_1Hz);
  endtask

  task automatic test_reset();
    set_inc(1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_1Hz);
    n_assert += 2;
    if ({bus.inc_short, bus.inc_long} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00", {bus.inc_short, bus.inc_long});
    end
    if ({bus0.inc_short, bus0.inc_long} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs_norep: got %b, required 00", {bus0.inc_short, bus0.inc_long});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int s0 = n_short, l0 = n_long;
    repeat (10) @(negedge clk_1Hz);
    n_assert++;
    if ((n_short - s0) + (n_long - l0) !== 0) begin
      n_fail++;
      $display("FAIL idle_pulses: got %0d pulses, required 0", (n_short - s0) + (n_long - l0));
    end
  endtask

  task automatic test_press(input string name, input int n, input int want_s, input int want_l);
    int s0 = n_short, l0 = n_long;
    press(n);
    settle();
    n_assert += 3;
    if (n_short - s0 !== want_s) begin
      n_fail++;
      $display("FAIL %s_short_count: got %0d, required %0d", name, n_short - s0, want_s);
    end
    if (n_long - l0 !== want_l) begin
      n_fail++;
      $display("FAIL %s_long_count: got %0d, required %0d", name, n_long - l0, want_l);
    end
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d expected pulses not seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int s0 = n_short, l0 = n_long;
    press(2);
    press(1);
    press(3);
    settle();
    n_assert += 3;
    if (n_short - s0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_short_count: got %0d, required 2", n_short - s0);
    end
    if (n_long - l0 !== 1) begin
      n_fail++;
      $display("FAIL b2b_long_count: got %0d, required 1", n_long - l0);
    end
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_pending: %0d expected pulses not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_press();
    int s0, l0, r;
    @(negedge clk_1Hz);
    s0 = n_short;
    l0 = n_long;
    set_inc(1'b1);
    repeat (S + 2) @(posedge clk_1Hz);  // hold count is now 2
    #2 rst_n = 1'b0;
    @(negedge clk_1Hz);
    n_assert++;
    if ({bus.inc_short, bus.inc_long} !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, required 00", {bus.inc_short, bus.inc_long});
    end
    @(negedge clk_1Hz);
    r = cyc + 1;
    rst_n = 1'b1;
    // still held: the press restarts from count 1, so 2 more samples is short
    exp_q.push_back('{cyc: r + S + 2, lng: 1'b0});
    repeat (2) @(negedge clk_1Hz);
    set_inc(1'b0);
    settle();
    n_assert += 3;
    if (n_short - s0 !== 1) begin
      n_fail++;
      $display("FAIL midreset_short_count: got %0d, required 1", n_short - s0);
    end
    if (n_long - l0 !== 0) begin
      n_fail++;
      $display("FAIL midreset_long_count: got %0d, required 0", n_long - l0);
    end
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_pending: %0d expected pulses not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_no_repeat();
    int s0 = r0_short, l0 = r0_long;
    press(10);
    settle();
    n_assert += 3;
    if (r0_long - l0 !== 1) begin
      n_fail++;
      $display("FAIL norep_long_count: got %0d, required 1", r0_long - l0);
    end
    if (r0_short - s0 !== 0) begin
      n_fail++;
      $display("FAIL norep_short_count: got %0d, required 0", r0_short - s0);
    end
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL norep_pending: %0d expected pulses not seen, required 0", exp_q.size());
    end
  endtask

  initial begin
    set_inc(1'b0);
    test_reset();
    test_idle();
    test_press("short", 2, 1, 0);
    test_press("long", 5, 0, 2);
    test_press("long_ext", 10, 0, 4);
    test_press("bound1", 1, 1, 0);
    test_press("bound2", 2, 1, 0);
    test_press("bound3", 3, 0, 1);
    test_back_to_back();
    test_reset_mid_press();
    test_no_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
